// File: rtl/branch_pkg.sv
// Shared encodings for the branch controller: FSM states, branch opcodes
// and comparator result codes.
package branch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_OPND = 2'd1,
    ST_RESOLVE   = 2'd2,
    ST_REDIRECT  = 2'd3
  } state_e;

  // Branch opcodes carried on br_op
  localparam logic [1:0] OP_BEQ = 2'b00;
  localparam logic [1:0] OP_BNE = 2'b01;
  localparam logic [1:0] OP_BLT = 2'b10;
  localparam logic [1:0] OP_BGT = 2'b11;

  // Comparator result codes carried on cmp_res
  localparam logic [1:0] CMP_EQ  = 2'b00;
  localparam logic [1:0] CMP_LT  = 2'b01;
  localparam logic [1:0] CMP_GT  = 2'b10;
  localparam logic [1:0] CMP_INV = 2'b11;

endpackage

// File: rtl/branch_cond_eval.sv
// Purely combinational branch condition evaluation: decides whether a branch
// with opcode br_op is taken given the external comparator's verdict.
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [1:0] br_op,
  input  logic [1:0] cmp_res,
  output logic       taken,
  output logic       invalid
);

  // An invalid comparison (X/Z operands) never lets the branch be taken.
  always_comb begin
    invalid = (cmp_res == CMP_INV);
    taken   = 1'b0;
    case (br_op)
      OP_BEQ:  taken = (cmp_res == CMP_EQ);
      OP_BNE:  taken = (cmp_res != CMP_EQ);
      OP_BLT:  taken = (cmp_res == CMP_LT);
      OP_BGT:  taken = (cmp_res == CMP_GT);
      default: taken = 1'b0;
    endcase
    if (invalid) begin
      taken = 1'b0;
    end
  end

endmodule

// File: rtl/branch_controller.sv
// Decode-stage branch controller: captures a branch, waits for its operands,
// resolves it against the external comparator and redirects the PC when taken.
// Pulses (pc_sel/flush/br_done/cmp_err) are combinational from the current
// state so that resolution lands one cycle after capture and redirect two.
module branch_controller
  import branch_pkg::*;
#(
  parameter int DW       = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          br_valid,
  input  logic [1:0]    br_op,
  input  logic [DW-1:0] pc_plus2,
  input  logic [DW-1:0] offset,
  input  logic          rs_busy,
  input  logic          rt_busy,
  input  logic [1:0]    cmp_res,
  input  logic          ext_flush,
  output logic          stall,
  output logic          flush,
  output logic          pc_sel,
  output logic [DW-1:0] branch_target,
  output logic          br_done,
  output logic          cmp_err,
  output logic [15:0]   br_count,
  output logic [15:0]   taken_count
);

  localparam int WCW = $clog2(WAIT_MAX + 1);

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [DW-1:0]   target_q, target_d;
  logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0]     br_count_q, br_count_d;
  logic [15:0]     taken_count_q, taken_count_d;

  logic            stall_c, pc_sel_c, done_c, err_c;
  logic            cond_taken, cond_invalid;

  branch_cond_eval u_cond (
    .br_op   (op_q),
    .cmp_res (cmp_res),
    .taken   (cond_taken),
    .invalid (cond_invalid)
  );

  // Next-state and output decode; ext_flush overrides whatever the FSM wanted.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    target_d      = target_q;
    wait_cnt_d    = wait_cnt_q;
    stall_c       = 1'b0;
    pc_sel_c      = 1'b0;
    done_c        = 1'b0;
    err_c         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        wait_cnt_d = '0;
        if (br_valid) begin
          stall_c  = 1'b1;
          op_d     = br_op;
          target_d = pc_plus2 + (offset << 1);
          state_d  = (rs_busy | rt_busy) ? ST_WAIT_OPND : ST_RESOLVE;
        end
      end
      ST_WAIT_OPND: begin
        stall_c = 1'b1;
        if (!(rs_busy | rt_busy)) begin
          wait_cnt_d = '0;
          state_d    = ST_RESOLVE;
        end else if (wait_cnt_q == WCW'(WAIT_MAX - 1)) begin
          // This cycle is the WAIT_MAX-th one spent waiting: give up.
          err_c      = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      ST_RESOLVE: begin
        stall_c = 1'b1;
        if (cond_invalid) begin
          err_c   = 1'b1;
          done_c  = 1'b1;
          state_d = ST_IDLE;
        end else if (cond_taken) begin
          state_d = ST_REDIRECT;
        end else begin
          done_c  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_REDIRECT: begin
        pc_sel_c = 1'b1;
        done_c   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A pipeline flush kills the branch in flight; a branch offered in the
    // same cycle is not captured, so the visible target stays unchanged.
    if (ext_flush) begin
      state_d    = ST_IDLE;
      op_d       = op_q;
      target_d   = target_q;
      wait_cnt_d = '0;
      pc_sel_c   = 1'b0;
      done_c     = 1'b0;
      err_c      = 1'b0;
    end

    br_count_d    = done_c   ? br_count_q + 16'd1    : br_count_q;
    taken_count_d = pc_sel_c ? taken_count_q + 16'd1 : taken_count_q;
  end

  // State, captured branch and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_BEQ;
      target_q      <= '0;
      wait_cnt_q    <= '0;
      br_count_q    <= '0;
      taken_count_q <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      target_q      <= target_d;
      wait_cnt_q    <= wait_cnt_d;
      br_count_q    <= br_count_d;
      taken_count_q <= taken_count_d;
    end
  end

  // Stall is partly driven by br_valid, so gate it with reset to keep all
  // outputs quiet while rst_n is low.
  assign stall         = stall_c & rst_n;
  assign pc_sel        = pc_sel_c;
  assign flush         = pc_sel_c;
  assign br_done       = done_c;
  assign cmp_err       = err_c;
  assign branch_target = target_q;
  assign br_count      = br_count_q;
  assign taken_count   = taken_count_q;

endmodule
